// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and IF/ID register, honours hazard-unit stalls
// and ID redirects, and keeps a one-word buffer so a word returned during a stall is kept.
//
// state | meaning
// REQ   | imem_req high, waiting for or consuming imem_rdata at pc
// BUF   | word for pc captured in buffer during a stall, request dropped
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        IF_ID_Write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        fetch_busy
);

  typedef enum logic {REQ, BUF} state_t;

  state_t      state, stateNext;
  logic [31:0] pc, pcNext, pcPlus4;
  logic [31:0] bufInstr, bufNext;
  logic [31:0] instrNext, pc4Next;
  logic        validNext;
  logic        adv, redir;

  // A PCWrite/IF_ID_Write disagreement is treated as a stall.
  assign adv     = PCWrite & IF_ID_Write;
  assign redir   = branch_taken & adv;
  assign pcPlus4 = pc + 32'd4;

  assign imem_addr  = pc;
  assign imem_req   = (state == REQ);
  assign fetch_busy = (state == REQ) & ~imem_ready;

  always_comb begin
    stateNext = state;
    pcNext    = pc;
    bufNext   = bufInstr;
    instrNext = if_id_instr;
    pc4Next   = if_id_pc4;
    validNext = if_id_valid;
    case (state)
      REQ: begin
        if (redir) begin
          pcNext    = branch_target;
          instrNext = NOP_INSTR;
          pc4Next   = 32'd0;
          validNext = 1'b0;
        end else if (imem_ready && adv) begin
          pcNext    = pcPlus4;
          instrNext = imem_rdata;
          pc4Next   = pcPlus4;
          validNext = 1'b1;
        end else if (imem_ready) begin
          bufNext   = imem_rdata;
          stateNext = BUF;
        end else if (adv) begin
          instrNext = NOP_INSTR;
          pc4Next   = 32'd0;
          validNext = 1'b0;
        end
      end
      BUF: begin
        if (redir) begin
          pcNext    = branch_target;
          instrNext = NOP_INSTR;
          pc4Next   = 32'd0;
          validNext = 1'b0;
          bufNext   = 32'd0;
          stateNext = REQ;
        end else if (adv) begin
          pcNext    = pcPlus4;
          instrNext = bufInstr;
          pc4Next   = pcPlus4;
          validNext = 1'b1;
          stateNext = REQ;
        end
      end
      default: stateNext = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= REQ;
      pc          <= RESET_PC;
      bufInstr    <= 32'd0;
      if_id_instr <= NOP_INSTR;
      if_id_pc4   <= 32'd0;
      if_id_valid <= 1'b0;
    end else begin
      state       <= stateNext;
      pc          <= pcNext;
      bufInstr    <= bufNext;
      if_id_instr <= instrNext;
      if_id_pc4   <= pc4Next;
      if_id_valid <= validNext;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: each step queues the expected pre-edge fetch outputs
// and post-edge IF/ID contents; a negedge monitor pops and compares them.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCWrite, IF_ID_Write, branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr, if_id_pc4;
  logic        if_id_valid, fetch_busy;

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .fetch_busy(fetch_busy)
  );

  always #5 clk = ~clk;

  // pre item: w0=imem_addr, b0=imem_req, b1=fetch_busy
  // post item: w0=if_id_instr, w1=if_id_pc4, b0=if_id_valid
  typedef struct {
    bit          isPost;
    int          id;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        b0;
    logic        b1;
  } exp_t;

  exp_t q[$];
  int   passCnt = 0;
  int   totalCnt = 0;
  int   stepId = 0;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t it;
      it = q.pop_front();
      totalCnt++;
      if (it.isPost) begin
        if (if_id_instr === it.w0 && if_id_pc4 === it.w1 && if_id_valid === it.b0)
          passCnt++;
        else
          $display("FAIL ifid step%0d: got instr=%h pc4=%h valid=%b, want instr=%h pc4=%h valid=%b",
                   it.id, if_id_instr, if_id_pc4, if_id_valid, it.w0, it.w1, it.b0);
      end else begin
        if (imem_addr === it.w0 && imem_req === it.b0 && fetch_busy === it.b1)
          passCnt++;
        else
          $display("FAIL fetch step%0d: got addr=%h req=%b busy=%b, want addr=%h req=%b busy=%b",
                   it.id, imem_addr, imem_req, fetch_busy, it.w0, it.b0, it.b1);
      end
    end
  end

  task automatic step(input logic rst, input logic pcw, input logic ifw, input logic br,
                      input logic [31:0] tgt, input logic rdy, input logic [31:0] rdata,
                      input bit chkPre, input logic [31:0] eAddr, input logic eReq,
                      input logic eBusy, input logic [31:0] eInstr, input logic [31:0] ePc4,
                      input logic eValid);
    exp_t e;
    stepId++;
    reset = rst; PCWrite = pcw; IF_ID_Write = ifw; branch_taken = br;
    branch_target = tgt; imem_ready = rdy; imem_rdata = rdata;
    if (chkPre) begin
      e.isPost = 1'b0; e.id = stepId; e.w0 = eAddr; e.w1 = 32'd0; e.b0 = eReq; e.b1 = eBusy;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    e.isPost = 1'b1; e.id = stepId; e.w0 = eInstr; e.w1 = ePc4; e.b0 = eValid; e.b1 = 1'b0;
    q.push_back(e);
  endtask

  initial begin
    //    rst pcw ifw br tgt           rdy rdata         chk addr          req busy instr         pc4           valid
    step(1, 1, 1, 0, 32'h0,         1, 32'h0,        0, 32'h0,         1, 0,   NOP,          32'h0,        0);
    // streaming with imem_ready=1
    step(0, 1, 1, 0, 32'h0,         1, 32'h100,      1, 32'h0,         1, 0,   32'h100,      32'h4,        1);
    step(0, 1, 1, 0, 32'h0,         1, 32'h104,      1, 32'h4,         1, 0,   32'h104,      32'h8,        1);
    // two-cycle stall at pc=8 with ready: word buffered, request dropped
    step(0, 0, 0, 0, 32'h0,         1, 32'h108,      1, 32'h8,         1, 0,   32'h104,      32'h8,        1);
    step(0, 0, 0, 0, 32'h0,         1, 32'hDEAD,     1, 32'h8,         0, 0,   32'h104,      32'h8,        1);
    step(0, 1, 1, 0, 32'h0,         1, 32'hBEEF,     1, 32'h8,         0, 0,   32'h108,      32'hC,        1);
    // redirect at pc=12 to 0x40
    step(0, 1, 1, 1, 32'h40,        1, 32'h10C,      1, 32'hC,         1, 0,   NOP,          32'h0,        0);
    step(0, 1, 1, 0, 32'h0,         1, 32'h140,      1, 32'h40,        1, 0,   32'h140,      32'h44,       1);
    // branch during stall (including PCWrite/IF_ID_Write mismatch) is ignored
    step(0, 0, 0, 1, 32'h80,        0, 32'h0,        1, 32'h44,        1, 1,   32'h140,      32'h44,       1);
    step(0, 1, 0, 1, 32'h80,        0, 32'h0,        1, 32'h44,        1, 1,   32'h140,      32'h44,       1);
    step(0, 0, 1, 1, 32'h80,        1, 32'h0,        1, 32'h44,        1, 0,   32'h140,      32'h44,       1);
    // branch is buffered? no: previous step went to BUF; re-present with adv=1 from BUF
    step(0, 1, 1, 1, 32'h20,        1, 32'h144,      1, 32'h44,        0, 0,   NOP,          32'h0,        0);
    // three wait cycles at 0x20
    step(0, 1, 1, 0, 32'h0,         0, 32'h0,        1, 32'h20,        1, 1,   NOP,          32'h0,        0);
    step(0, 1, 1, 0, 32'h0,         0, 32'h0,        1, 32'h20,        1, 1,   NOP,          32'h0,        0);
    step(0, 1, 1, 0, 32'h0,         0, 32'h0,        1, 32'h20,        1, 1,   NOP,          32'h0,        0);
    step(0, 1, 1, 0, 32'h0,         1, 32'h120,      1, 32'h20,        1, 0,   32'h120,      32'h24,       1);
    // reset while in BUF
    step(0, 0, 0, 0, 32'h0,         1, 32'h124,      1, 32'h24,        1, 0,   32'h120,      32'h24,       1);
    step(1, 0, 0, 0, 32'h0,         1, 32'h0,        1, 32'h24,        0, 0,   NOP,          32'h0,        0);
    step(0, 1, 1, 0, 32'h0,         1, 32'h100,      1, 32'h0,         1, 0,   32'h100,      32'h4,        1);
    // reset mid-wait
    step(0, 1, 1, 0, 32'h0,         0, 32'h0,        1, 32'h4,         1, 1,   NOP,          32'h0,        0);
    step(1, 1, 1, 0, 32'h0,         0, 32'h0,        1, 32'h4,         1, 1,   NOP,          32'h0,        0);
    step(0, 1, 1, 0, 32'h0,         1, 32'h100,      1, 32'h0,         1, 0,   32'h100,      32'h4,        1);
    // redirect out of BUF
    step(0, 0, 0, 0, 32'h0,         1, 32'h104,      1, 32'h4,         1, 0,   32'h100,      32'h4,        1);
    step(0, 1, 1, 1, 32'h60,        1, 32'h0,        1, 32'h4,         0, 0,   NOP,          32'h0,        0);
    step(0, 1, 1, 0, 32'h0,         1, 32'h160,      1, 32'h60,        1, 0,   32'h160,      32'h64,       1);
    // PC wrap at the top of the address space
    step(0, 1, 1, 1, 32'hFFFF_FFFC, 1, 32'h0,        1, 32'h64,        1, 0,   NOP,          32'h0,        0);
    step(0, 1, 1, 0, 32'h0,         1, 32'hFC,       1, 32'hFFFF_FFFC, 1, 0,   32'hFC,       32'h0,        1);
    step(0, 1, 1, 0, 32'h0,         1, 32'h1,        1, 32'h0,         1, 0,   32'h1,        32'h4,        1);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      totalCnt++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch end of the load-use stall interface: owns the PC register and the IF/ID pipeline register.
- Obeys the hazard unit's PCWrite / IF_ID_Write stall enables (1 = advance, 0 = hold) and branch redirects resolved in ID.
- Drives a level-based instruction-memory request with variable latency.
- Holds a one-entry buffer so a fetched word is never lost or refetched during a stall.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID for bubbles and flushes

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
PCWrite  input  1  from hazard unit; 0 = hold PC
IF_ID_Write  input  1  from hazard unit; 0 = hold IF/ID contents
branch_taken  input  1  from ID; redirect fetch to branch_target
branch_target  input  32  redirect address
imem_req  output  1  instruction read request (level)
imem_addr  output  32  read address, equals current PC
imem_ready  input  1  imem_rdata valid for imem_addr this cycle
imem_rdata  input  32  instruction word
if_id_instr  output  32  IF/ID instruction register
if_id_pc4  output  32  IF/ID PC+4 register
if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble)
fetch_busy  output  1  REQ state and imem_ready=0 (fetch-side stall, informational)

Behaviour:
- Advance enable: adv = PCWrite & IF_ID_Write. The hazard unit drives both identically; a mismatch is treated as a stall.
- Redirect: redir = branch_taken & adv. A stall has priority, so a branch seen during a stall is ignored. ID re-presents it when the stall releases.
- Reset, synchronous, applied in any state and mid-request:
  - pc=RESET_PC, state=REQ, buffer cleared.
  - if_id_instr=NOP_INSTR, if_id_pc4=0, if_id_valid=0.
- imem_addr=pc, combinational. imem_req=1 iff state==REQ.
- The memory protocol has no outstanding transactions. imem_ready is sampled only for the current imem_addr in the same cycle. Dropping the request or changing the address abandons the read.
- Arithmetic: PC+4 is a 32-bit add; wrap 32'hFFFF_FFFC -> 0 is silent.
- State REQ:
  - redir: pc<=branch_target; IF/ID <= {NOP_INSTR, 0, valid 0}; any imem_rdata this cycle discarded; stay REQ.
  - else imem_ready & adv: IF/ID <= {imem_rdata, pc+4, 1}; pc<=pc+4; stay REQ.
  - else imem_ready & ~adv: buffer <= imem_rdata; IF/ID and pc held; go BUF.
  - else ~imem_ready & adv: IF/ID loads bubble {NOP_INSTR, 0, 0}; pc held; stay REQ.
  - else (~imem_ready & ~adv): everything held.
- State BUF (imem_req=0):
  - redir: pc<=branch_target; IF/ID flushed to bubble; buffer dropped; go REQ.
  - else adv: IF/ID <= {buffer, pc+4, 1}; pc<=pc+4; go REQ.
  - else: hold everything, stay BUF.
- Latency: one instruction per cycle when imem_ready stays 1 and no stalls; first valid IF/ID is the cycle after the first ready.
- Redirect penalty: exactly one bubble in IF/ID, plus any memory wait cycles.
- A stall never drops or duplicates an instruction. Each PC value appears in IF/ID with valid=1 exactly once, unless flushed by a redirect.

Test Plan:
- Reset, imem_ready=1 constant, rdata=pc|0x100 -> if_id_valid rises cycle after reset release; if_id_pc4 sequence 4,8,12; imem_addr 0,4,8.
- IF_ID_Write=PCWrite=0 for 2 cycles while imem_ready=1 at pc=8 -> state BUF, imem_req=0, IF/ID holds pc4=8 entry. On release, IF/ID gets instr 0x108 with pc4=12, then fetch resumes at 12; no duplicate, no loss.
- branch_taken=1, branch_target=0x40 with adv=1 at pc=12 -> next IF/ID valid=0 with instr NOP_INSTR; imem_addr=0x40; following IF/ID pc4=0x44.
- branch_taken=1 concurrent with stall (adv=0) -> pc unchanged, IF/ID unchanged; redirect takes effect only when re-presented with adv=1.
- imem_ready low 3 cycles at pc=0x20 with adv=1 -> fetch_busy=1; 3 bubbles (valid=0); imem_addr stays 0x20; then valid instr with pc4=0x24.
- Assert reset while in BUF and mid-wait -> next cycle pc=RESET_PC, if_id_valid=0, imem_req=1; pc=0xFFFFFFFC advancing -> pc wraps to 0.
